// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: frame constants, FSM states, parity/frame
// helpers and the ASCII to set-2 make-code table (kept in sync with the decoder).
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam int         PS2_FRAME_LEN = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic       supported;
    logic [7:0] code;
  } scan_t;

  function automatic logic ps2_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Frame bit 0 goes out first: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ps2_parity(data), data, 1'b0};
  endfunction

  function automatic scan_t ascii_to_scan(input logic [7:0] ch);
    logic [7:0] up;
    scan_t      r;
    up          = ((ch >= 8'h61) && (ch <= 8'h7A)) ? (ch - 8'h20) : ch;
    r.supported = 1'b1;
    case (up)
      8'h41: r.code = 8'h1C;  8'h42: r.code = 8'h32;  8'h43: r.code = 8'h21;
      8'h44: r.code = 8'h23;  8'h45: r.code = 8'h24;  8'h46: r.code = 8'h2B;
      8'h47: r.code = 8'h34;  8'h48: r.code = 8'h33;  8'h49: r.code = 8'h43;
      8'h4A: r.code = 8'h3B;  8'h4B: r.code = 8'h42;  8'h4C: r.code = 8'h4B;
      8'h4D: r.code = 8'h3A;  8'h4E: r.code = 8'h31;  8'h4F: r.code = 8'h44;
      8'h50: r.code = 8'h4D;  8'h51: r.code = 8'h15;  8'h52: r.code = 8'h2D;
      8'h53: r.code = 8'h1B;  8'h54: r.code = 8'h2C;  8'h55: r.code = 8'h3C;
      8'h56: r.code = 8'h2A;  8'h57: r.code = 8'h1D;  8'h58: r.code = 8'h22;
      8'h59: r.code = 8'h35;  8'h5A: r.code = 8'h1A;
      8'h30: r.code = 8'h45;  8'h31: r.code = 8'h16;  8'h32: r.code = 8'h1E;
      8'h33: r.code = 8'h26;  8'h34: r.code = 8'h25;  8'h35: r.code = 8'h2E;
      8'h36: r.code = 8'h36;  8'h37: r.code = 8'h3D;  8'h38: r.code = 8'h3E;
      8'h39: r.code = 8'h46;
      default: begin
        r.supported = 1'b0;
        r.code      = 8'h00;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ascii_to_ps2_code.sv
// Combinational ASCII to set-2 make-code lookup; lowercase folds onto uppercase.
module ascii_to_ps2_code
  import ps2_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] code,
  output logic       supported
);

  scan_t scan_s;

  // Table lookup through the shared package function
  always_comb begin
    scan_s    = ascii_to_scan(ascii);
    code      = scan_s.code;
    supported = scan_s.supported;
  end

endmodule

// File: rtl/ascii_ps2_kbd_tx.sv
// Keyboard-side PS/2 emulator: one ASCII character in, make [F0 make] frames out
// on registered ps2_clk/ps2_data lines.
module ascii_ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16,
  parameter bit SEND_BREAK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       err
);

  localparam int SLOT_W = $clog2(2 * CLK_DIV);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(CLK_DIV);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(PS2_FRAME_LEN - 1);
  localparam logic [1:0]        LAST_BYTE = SEND_BREAK ? 2'd2 : 2'd0;

  ps2_state_e        state_r, state_s;
  logic [SLOT_W-1:0] slot_r, slot_s;
  logic [3:0]        bit_r, bit_s;
  logic [GAP_W-1:0]  gap_r, gap_s;
  logic [1:0]        byte_idx_r, byte_idx_s;
  logic [7:0]        code_r, code_s;
  logic [10:0]       frame_r, frame_s;
  logic              ps2_clk_r, ps2_clk_s;
  logic              ps2_data_r, ps2_data_s;
  logic              busy_r, busy_s;
  logic              err_r, err_s;
  logic [7:0]        lut_code_s;
  logic              lut_supported_s;

  ascii_to_ps2_code u_lut (
    .ascii     (ascii_in),
    .code      (lut_code_s),
    .supported (lut_supported_s)
  );

  // Next-state, counter and line computation; outputs derive from the next state
  // so that every line is a flop aligned with the FSM.
  always_comb begin
    state_s    = state_r;
    slot_s     = slot_r;
    bit_s      = bit_r;
    gap_s      = gap_r;
    byte_idx_s = byte_idx_r;
    code_s     = code_r;
    frame_s    = frame_r;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (ascii_valid && lut_supported_s) begin
          state_s    = SEND;
          slot_s     = '0;
          bit_s      = 4'd0;
          byte_idx_s = 2'd0;
          code_s     = lut_code_s;
          frame_s    = ps2_frame(lut_code_s);
        end else if (ascii_valid) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      SEND: begin
        if (slot_r == SLOT_LAST) begin
          slot_s = '0;
          if (bit_r == BIT_LAST) begin
            state_s = GAP;
            gap_s   = '0;
          end else begin
            bit_s   = bit_r + 4'd1;
            frame_s = {1'b1, frame_r[10:1]};
          end
        end else begin
          slot_s = slot_r + SLOT_W'(1);
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_s = '0;
          if (byte_idx_r != LAST_BYTE) begin
            state_s    = SEND;
            byte_idx_s = byte_idx_r + 2'd1;
            slot_s     = '0;
            bit_s      = 4'd0;
            frame_s    = ps2_frame((byte_idx_r == 2'd0) ? PS2_BREAK : code_r);
          end else begin
            state_s = IDLE;
          end
        end else begin
          gap_s = gap_r + GAP_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (state_s == SEND) begin
      ps2_clk_s  = (slot_s < SLOT_HALF);
      ps2_data_s = frame_s[0];
    end else begin
      ps2_clk_s  = 1'b1;
      ps2_data_s = 1'b1;
    end
    busy_s = (state_s != IDLE);
  end

  // State, counters and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      slot_r     <= '0;
      bit_r      <= 4'd0;
      gap_r      <= '0;
      byte_idx_r <= 2'd0;
      code_r     <= 8'h00;
      frame_r    <= 11'h7FF;
      ps2_clk_r  <= 1'b1;
      ps2_data_r <= 1'b1;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      slot_r     <= slot_s;
      bit_r      <= bit_s;
      gap_r      <= gap_s;
      byte_idx_r <= byte_idx_s;
      code_r     <= code_s;
      frame_r    <= frame_s;
      ps2_clk_r  <= ps2_clk_s;
      ps2_data_r <= ps2_data_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
    end
  end

  assign ascii_ready = (state_r == IDLE) && !rst;
  assign ps2_clk     = ps2_clk_r;
  assign ps2_data    = ps2_data_r;
  assign busy        = busy_r;
  assign err         = err_r;

endmodule

// File: tb/tb_ascii_ps2_kbd_tx.sv
// Bench for ascii_ps2_kbd_tx: a waveform-queue model checked every cycle for a
// SEND_BREAK=1 and a SEND_BREAK=0 instance, plus directed literal checks.
module tb_ascii_ps2_kbd_tx;

  localparam int CD  = 4;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld0, vld1;
  logic [7:0] chr0, chr1;
  logic       rdy0, pclk0, pdat0, bsy0, er0;
  logic       rdy1, pclk1, pdat1, bsy1, er1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ascii_ps2_kbd_tx #(.CLK_DIV(CD), .GAP_CYCLES(GAP), .SEND_BREAK(1'b1)) dut0 (
    .clk(clk), .rst(rst), .ascii_in(chr0), .ascii_valid(vld0), .ascii_ready(rdy0),
    .ps2_clk(pclk0), .ps2_data(pdat0), .busy(bsy0), .err(er0));

  ascii_ps2_kbd_tx #(.CLK_DIV(CD), .GAP_CYCLES(GAP), .SEND_BREAK(1'b0)) dut1 (
    .clk(clk), .rst(rst), .ascii_in(chr1), .ascii_valid(vld1), .ascii_ready(rdy1),
    .ps2_clk(pclk1), .ps2_data(pdat1), .busy(bsy1), .err(er1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-cycle {ps2_clk, ps2_data} of the sequence in flight
  logic [1:0]  q0[$];
  logic [1:0]  q1[$];
  logic [7:0]  dec0[$];
  logic [7:0]  dec1[$];
  logic [10:0] fr0[$];
  logic        eerr0 = 1'b0, eerr1 = 1'b0;
  logic        m_rdy0 = 1'b0, m_rdy1 = 1'b0;
  int          acc_cnt0 = 0, acc_step0 = 0, step = 0;
  int          bcnt0 = 0, bcnt1 = 0, ecnt0 = 0, low0 = 0;
  logic        s_rst = 1'b1, s_vld0 = 1'b0, s_vld1 = 1'b0;
  logic [7:0]  s_chr0 = 8'h00, s_chr1 = 8'h00;

  function automatic bit scan_of(input logic [7:0] ch, output logic [7:0] code);
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};
    code = 8'h00;
    if (ch >= 8'h41 && ch <= 8'h5A) code = letters[int'(ch) - 8'h41];
    else if (ch >= 8'h61 && ch <= 8'h7A) code = letters[int'(ch) - 8'h61];
    else if (ch >= 8'h30 && ch <= 8'h39) code = digits[int'(ch) - 8'h30];
    else return 1'b0;
    return 1'b1;
  endfunction

  function automatic void push_wave(input int inst, input logic [7:0] b);
    logic [10:0] f;
    logic [1:0]  e;
    f = {1'b1, (($countones(b) % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int h = 0; h < 2 * CD; h++) begin
        e = {(h < CD) ? 1'b1 : 1'b0, f[k]};
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    for (int g = 0; g < GAP; g++) begin
      if (inst == 0) q0.push_back(2'b11); else q1.push_back(2'b11);
    end
  endfunction

  // Sample inputs exactly as the DUT sees them at the rising edge
  always @(posedge clk) begin
    s_rst  <= rst;
    s_vld0 <= vld0;
    s_vld1 <= vld1;
    s_chr0 <= chr0;
    s_chr1 <= chr1;
  end

  // Advance the model by the edge just taken, then compare and decode mid-cycle
  always @(negedge clk) begin : mdl
    logic [7:0]  c;
    logic [1:0]  e;
    logic        pp0, pp1;
    int          dn0, dn1;
    logic [10:0] sh0, sh1;
    step++;
    eerr0 = 1'b0;
    eerr1 = 1'b0;
    if (s_rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() != 0) void'(q0.pop_front());
      else if (s_vld0) begin
        if (scan_of(s_chr0, c)) begin
          push_wave(0, c); push_wave(0, 8'hF0); push_wave(0, c);
          acc_cnt0++;
          acc_step0 = step;
        end else eerr0 = 1'b1;
      end
      if (q1.size() != 0) void'(q1.pop_front());
      else if (s_vld1) begin
        if (scan_of(s_chr1, c)) push_wave(1, c);
        else eerr1 = 1'b1;
      end
    end
    m_rdy0 = (q0.size() == 0) && !rst;
    m_rdy1 = (q1.size() == 0) && !rst;

    e = (q0.size() != 0) ? q0[0] : 2'b11;
    chk("cyc_clk0", pclk0, e[1]);
    chk("cyc_data0", pdat0, e[0]);
    chk("cyc_busy0", bsy0, q0.size() != 0);
    chk("cyc_ready0", rdy0, m_rdy0);
    chk("cyc_err0", er0, eerr0);
    e = (q1.size() != 0) ? q1[0] : 2'b11;
    chk("cyc_clk1", pclk1, e[1]);
    chk("cyc_data1", pdat1, e[0]);
    chk("cyc_busy1", bsy1, q1.size() != 0);
    chk("cyc_ready1", rdy1, m_rdy1);
    chk("cyc_err1", er1, eerr1);

    if (bsy0) bcnt0++;
    if (bsy1) bcnt1++;
    if (er0) ecnt0++;
    if (!pclk0 || !pdat0) low0++;

    // Receiver: sample data on ps2_clk falling edges
    if (rst) begin
      dn0 = 0; dn1 = 0;
    end else begin
      if (pp0 && !pclk0) begin
        sh0 = {pdat0, sh0[10:1]};
        dn0++;
        if (dn0 == 11) begin
          dn0 = 0;
          chk("frame_start0", sh0[0], 1'b0);
          chk("frame_stop0", sh0[10], 1'b1);
          chk("frame_parity0", ^sh0[9:1], 1'b1);
          dec0.push_back(sh0[8:1]);
          fr0.push_back(sh0);
        end
      end
      if (pp1 && !pclk1) begin
        sh1 = {pdat1, sh1[10:1]};
        dn1++;
        if (dn1 == 11) begin
          dn1 = 0;
          chk("frame_parity1", ^sh1[9:1], 1'b1);
          dec1.push_back(sh1[8:1]);
        end
      end
    end
    pp0 = pclk0;
    pp1 = pclk1;
  end

  // Offer a character and drop valid right after the accepting edge
  task automatic send(input int inst, input logic [7:0] ch);
    bit done = 1'b0;
    if (inst == 0) begin vld0 = 1'b1; chr0 = ch; end
    else begin vld1 = 1'b1; chr1 = ch; end
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      done = (inst == 0) ? m_rdy0 : m_rdy1;
    end
    vld0 = 1'b0;
    vld1 = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int inst);
    bit done = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      done = (inst == 0) ? m_rdy0 : m_rdy1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear0();
    dec0.delete(); fr0.delete(); bcnt0 = 0; ecnt0 = 0; low0 = 0;
  endtask

  task automatic chk_seq(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c);
    chk({name, "_nbytes"}, dec0.size(), 3);
    if (dec0.size() == 3) begin
      chk({name, "_b0"}, dec0[0], a);
      chk({name, "_b1"}, dec0[1], b);
      chk({name, "_b2"}, dec0[2], c);
    end
  endtask

  initial begin
    int a1, bz_acc;
    logic [7:0] bz [6] = '{8'h32, 8'hF0, 8'h32, 8'h1A, 8'hF0, 8'h1A};
    rst = 1'b1; vld0 = 1'b0; vld1 = 1'b0; chr0 = 8'h00; chr1 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_clk", pclk0, 1'b1);
    chk("rst_data", pdat0, 1'b1);
    chk("rst_busy", bsy0, 1'b0);
    chk("rst_err", er0, 1'b0);
    @(posedge clk); #1;

    clear0();
    send(0, 8'h41); wait_idle(0);
    chk("A_busy_cycles", bcnt0, 312);
    chk_seq("A", 8'h1C, 8'hF0, 8'h1C);
    if (fr0.size() == 3) begin
      chk("A_frame0_bits", fr0[0], 11'h438);
      chk("A_frame1_bits", fr0[1], 11'h7E0);
    end

    clear0();
    send(0, 8'h61); wait_idle(0);
    chk("a_busy_cycles", bcnt0, 312);
    chk_seq("a", 8'h1C, 8'hF0, 8'h1C);

    clear0();
    send(0, 8'h30); wait_idle(0);
    chk_seq("zero", 8'h45, 8'hF0, 8'h45);
    if (fr0.size() != 0) chk("zero_parity", fr0[0][9], 1'b0);

    clear0();
    send(0, 8'h20);
    repeat (20) @(posedge clk);
    #1;
    chk("unsup_err_cycles", ecnt0, 1);
    chk("unsup_busy_cycles", bcnt0, 0);
    chk("unsup_line_low_cycles", low0, 0);
    chk("unsup_ready", rdy0, 1'b1);

    clear0();
    vld0 = 1'b1; chr0 = 8'h42;
    a1 = acc_cnt0;
    for (int i = 0; i < 100 && acc_cnt0 == a1; i++) begin @(posedge clk); #1; end
    bz_acc = acc_step0;
    chr0 = 8'h5A;
    for (int i = 0; i < 1000 && acc_cnt0 < a1 + 2; i++) begin @(posedge clk); #1; end
    vld0 = 1'b0;
    chk("b2b_accepts", acc_cnt0 - a1, 2);
    chk("b2b_accept_spacing", acc_step0 - bz_acc, 313);
    wait_idle(0);
    chk("b2b_nbytes", dec0.size(), 6);
    if (dec0.size() == 6)
      for (int i = 0; i < 6; i++) chk("b2b_byte", dec0[i], bz[i]);

    send(0, 8'h41);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_clk", pclk0, 1'b1);
    chk("midrst_data", pdat0, 1'b1);
    chk("midrst_busy", bsy0, 1'b0);
    chk("midrst_ready", rdy0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_ready", rdy0, 1'b1);
    @(posedge clk); #1;
    clear0();
    send(0, 8'h51); wait_idle(0);
    chk_seq("Q", 8'h15, 8'hF0, 8'h15);

    dec1.delete(); bcnt1 = 0;
    send(1, 8'h39); wait_idle(1);
    chk("nb_busy_cycles", bcnt1, 104);
    chk("nb_nbytes", dec1.size(), 1);
    if (dec1.size() != 0) chk("nb_byte", dec1[0], 8'h46);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
